// File: rtl/aes_job_ctrl.sv
// AES job controller: per-channel job FIFOs, a round-robin dispatcher and the request/start/run sequencer.
// Define AES_CTRL_WATCHDOG_EN to add a RUN-state watchdog that raises err_o and closes out a stalled job.
module aes_job_ctrl #(
    parameter int N_CORES     = 1,
    parameter int N_CHAN      = 2,
    parameter int Q_DEPTH     = 4,
    parameter int LEN_W       = 16,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          clear_i,
    input  logic                                          job_valid_i,
    output logic                                          job_ready_o,
    input  logic [((N_CHAN > 1) ? $clog2(N_CHAN) : 1)-1:0]   job_chan_i,
    input  logic [((N_CORES > 1) ? $clog2(N_CORES) : 1)-1:0] job_core_i,
    input  logic                                          job_mode_i,
    input  logic [ADDR_W-1:0]                             job_src_i,
    input  logic [ADDR_W-1:0]                             job_dst_i,
    input  logic [LEN_W-1:0]                              job_nblk_i,
    output logic                                          src_valid_o,
    input  logic                                          src_ready_i,
    output logic [ADDR_W-1:0]                             src_addr_o,
    output logic [LEN_W-1:0]                              src_len_o,
    output logic                                          snk_valid_o,
    input  logic                                          snk_ready_i,
    output logic [ADDR_W-1:0]                             snk_addr_o,
    output logic [LEN_W-1:0]                              snk_len_o,
    output logic                                          eng_start_o,
    output logic                                          eng_mode_o,
    input  logic                                          eng_blk_done_i,
    output logic                                          busy_o,
    output logic [((N_CHAN > 1) ? $clog2(N_CHAN) : 1)-1:0]   cur_chan_o,
    output logic                                          err_o,
    output logic [N_CORES-1:0]                            evt_o
);
    localparam int CHAN_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int PTR_W  = $clog2(Q_DEPTH);

    typedef struct packed {
        logic [CORE_W-1:0] core;
        logic              mode;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  nblk;
    } job_t;

    typedef enum logic [2:0] {IDLE, SRC_REQ, SNK_REQ, START, RUN, DONE} state_t;

    job_t fifo_mem [N_CHAN][Q_DEPTH];
    job_t job_in, head, job_q, job_d;

    logic [N_CHAN-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [N_CHAN-1:0][PTR_W:0]   cnt_q, cnt_d;

    state_t             state_q, state_d;
    logic [CHAN_W-1:0]  rr_q, rr_d, chan_q, chan_d, pop_chan;
    logic [LEN_W-1:0]   blk_cnt_q, blk_cnt_d, blk_nxt;
    logic               src_valid_q, src_valid_d, snk_valid_q, snk_valid_d;
    logic               start_q, start_d, busy_q, busy_d;
    logic [N_CORES-1:0] evt_q, evt_d;
    logic               push, pop, found;
    int                 idx;

`ifdef AES_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d, wd_nxt;
    logic            err_q, err_d;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign job_in = '{core: job_core_i, mode: job_mode_i, src: job_src_i,
                      dst: job_dst_i, nblk: job_nblk_i};

    // Round-robin search starts at rr_q, the channel after the last one served.
    always_comb begin
        job_ready_o = (int'(job_chan_i) < N_CHAN) && (cnt_q[job_chan_i] != (PTR_W+1)'(Q_DEPTH));
        found    = 1'b0;
        pop_chan = '0;
        idx      = 0;
        for (int i = 0; i < N_CHAN; i++) begin
            idx = (int'(rr_q) + i) % N_CHAN;
            if (!found && cnt_q[idx] != '0) begin
                found    = 1'b1;
                pop_chan = CHAN_W'(idx);
            end
        end
        head = fifo_mem[pop_chan][rd_ptr_q[pop_chan]];
        push = job_valid_i && job_ready_o && !clear_i;
        pop  = (state_q == IDLE) && found && !clear_i;
    end

    always_comb begin
        for (int c = 0; c < N_CHAN; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            cnt_d[c]    = cnt_q[c];
            if (clear_i) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                cnt_d[c]    = '0;
            end else begin
                if (push && job_chan_i == CHAN_W'(c)) begin
                    wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
                    cnt_d[c]    = cnt_d[c] + 1'b1;
                end
                if (pop && pop_chan == CHAN_W'(c)) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
                    cnt_d[c]    = cnt_d[c] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        job_d     = job_q;
        chan_d    = chan_q;
        rr_d      = rr_q;
        blk_cnt_d = blk_cnt_q;
        blk_nxt   = blk_cnt_q + 1'b1;
`ifdef AES_CTRL_WATCHDOG_EN
        wd_d      = wd_q;
        wd_nxt    = wd_q + 1'b1;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: if (pop) begin
                job_d   = head;
                chan_d  = pop_chan;
                rr_d    = (pop_chan == CHAN_W'(N_CHAN - 1)) ? '0 : pop_chan + 1'b1;
                state_d = (head.nblk == '0) ? DONE : SRC_REQ;
            end
            SRC_REQ: if (src_ready_i) state_d = SNK_REQ;
            SNK_REQ: if (snk_ready_i) state_d = START;
            START: begin
                blk_cnt_d = '0;
`ifdef AES_CTRL_WATCHDOG_EN
                wd_d      = '0;
`endif
                state_d   = RUN;
            end
            RUN: begin
                if (eng_blk_done_i) begin
                    blk_cnt_d = blk_nxt;
                    if (blk_nxt == job_q.nblk) state_d = DONE;
`ifdef AES_CTRL_WATCHDOG_EN
                    wd_d = '0;
                end else if (wd_nxt == WD_W'(TIMEOUT_CYC)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_d = wd_nxt;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d   = IDLE;
            blk_cnt_d = '0;
            rr_d      = '0;
`ifdef AES_CTRL_WATCHDOG_EN
            wd_d      = '0;
            err_d     = 1'b0;
`endif
        end
        // Outputs are decoded from the next state so they come straight off flops.
        src_valid_d = (state_d == SRC_REQ);
        snk_valid_d = (state_d == SNK_REQ);
        start_d     = (state_d == START);
        busy_d      = (state_d != IDLE);
        evt_d       = (state_d == DONE) ? (N_CORES'(1) << job_d.core) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[job_chan_i][wr_ptr_q[job_chan_i]] <= job_in;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            job_q       <= '0;
            chan_q      <= '0;
            rr_q        <= '0;
            blk_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            src_valid_q <= 1'b0;
            snk_valid_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            evt_q       <= '0;
`ifdef AES_CTRL_WATCHDOG_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            chan_q      <= chan_d;
            rr_q        <= rr_d;
            blk_cnt_q   <= blk_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            src_valid_q <= src_valid_d;
            snk_valid_q <= snk_valid_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            evt_q       <= evt_d;
`ifdef AES_CTRL_WATCHDOG_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign src_valid_o = src_valid_q;
    assign src_addr_o  = job_q.src;
    assign src_len_o   = job_q.nblk;
    assign snk_valid_o = snk_valid_q;
    assign snk_addr_o  = job_q.dst;
    assign snk_len_o   = job_q.nblk;
    assign eng_start_o = start_q;
    assign eng_mode_o  = job_q.mode;
    assign busy_o      = busy_q;
    assign cur_chan_o  = chan_q;
    assign evt_o       = evt_q;

endmodule

// File: tb/tb_aes_job_ctrl.sv
// Scoreboard bench for aes_job_ctrl: stimulus queues expected streamer/engine/event outputs,
// a negedge monitor pops and compares them, and a responder supplies engine block-done pulses.
module tb_aes_job_ctrl;
    localparam int N_CORES = 2;
    localparam int N_CHAN  = 2;

    logic        clk = 1'b0, rst = 1'b0, clear = 1'b0;
    logic        job_valid = 1'b0, job_ready, job_chan = 1'b0, job_core = 1'b0, job_mode = 1'b0;
    logic [31:0] job_src = '0, job_dst = '0;
    logic [15:0] job_nblk = '0;
    logic        src_valid, src_ready = 1'b0, snk_valid, snk_ready = 1'b1;
    logic [31:0] src_addr, snk_addr;
    logic [15:0] src_len, snk_len;
    logic        eng_start, eng_mode, blk_done = 1'b0, busy, cur_chan, err;
    logic [1:0]  evt;

    typedef struct { int kind; logic [31:0] a; logic [31:0] b; } exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0;
    bit auto_done = 1'b0;
    int kick_seq = 0, kick_len = 0;

    aes_job_ctrl #(.N_CORES(N_CORES), .N_CHAN(N_CHAN), .Q_DEPTH(4), .LEN_W(16),
                   .ADDR_W(32), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_chan_i(job_chan),
        .job_core_i(job_core), .job_mode_i(job_mode), .job_src_i(job_src),
        .job_dst_i(job_dst), .job_nblk_i(job_nblk),
        .src_valid_o(src_valid), .src_ready_i(src_ready), .src_addr_o(src_addr), .src_len_o(src_len),
        .snk_valid_o(snk_valid), .snk_ready_i(snk_ready), .snk_addr_o(snk_addr), .snk_len_o(snk_len),
        .eng_start_o(eng_start), .eng_mode_o(eng_mode), .eng_blk_done_i(blk_done),
        .busy_o(busy), .cur_chan_o(cur_chan), .err_o(err), .evt_o(evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    task automatic sb_check(input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got kind %0d a=%0h b=%0h, required no output", kind, a, b);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                fails++;
                $display("FAIL sb_compare: got kind %0d a=%0h b=%0h, required kind %0d a=%0h b=%0h",
                         kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    // kinds: 0 src request, 1 sink request, 2 engine start, 3 completion event
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (src_valid && src_ready) sb_check(0, src_addr, 32'(src_len));
            if (snk_valid && snk_ready) sb_check(1, snk_addr, 32'(snk_len));
            if (eng_start)              sb_check(2, 32'(eng_mode), 32'd0);
            if (evt != 2'b00)           sb_check(3, 32'(evt), 32'd0);
        end
    end

    // Engine model: either follows each start automatically or serves a one-off kick.
    initial begin
        int n, kick_seen;
        kick_seen = 0;
        forever begin
            @(negedge clk);
            n = 0;
            if (eng_start && auto_done) n = int'(src_len);
            else if (kick_seq != kick_seen) begin
                kick_seen = kick_seq;
                n = kick_len;
            end
            if (n > 0) begin
                for (int k = 0; k < n; k++) begin
                    @(posedge clk); #1 blk_done = 1'b1;
                    @(posedge clk); #1 blk_done = 1'b0;
                end
                @(negedge clk);
                chk("evt_after_last_blk", 32'(evt != 2'b00), 32'd1);
            end
        end
    end

    // Call at posedge+#1; returns at posedge+#1 after the push edge.
    task automatic push_job(input int chan, input int core, input bit mode, input logic [31:0] src,
                            input logic [31:0] dst, input int nblk, input bit exp_acc, input bit rec);
        job_chan = 1'(chan); job_core = 1'(core); job_mode = mode;
        job_src = src; job_dst = dst; job_nblk = 16'(nblk); job_valid = 1'b1;
        @(negedge clk);
        chk("job_ready", 32'(job_ready), 32'(exp_acc));
        @(posedge clk); #1 job_valid = 1'b0;
        if (exp_acc && rec) begin
            if (nblk != 0) begin
                sb.push_back('{0, src, 32'(nblk)});
                sb.push_back('{1, dst, 32'(nblk)});
                sb.push_back('{2, 32'(mode), 32'd0});
            end
            sb.push_back('{3, 32'(1 << core), 32'd0});
        end
    endtask

    task automatic wait_start(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = eng_start;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic wait_drain(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && !busy;
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic kick(input int n);
        kick_len = n;
        kick_seq++;
    endtask

    initial begin
        int seen;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {26'd0, src_valid, snk_valid, eng_start, err, evt}, 32'd0);
        chk("rst_chan_mode", {30'd0, cur_chan, eng_mode}, 32'd0);

        // single job right after reset release: src request two cycles after push, held until ready
        rst = 1'b0;
        auto_done = 1'b1;
        push_job(0, 0, 1'b0, 32'h1000, 32'h2000, 3, 1'b1, 1'b1);
        @(negedge clk); chk("t1_src_t1", 32'(src_valid), 32'd0);
        @(negedge clk); chk("t1_src_t2", 32'(src_valid), 32'd1);
        chk("t1_src_addr", src_addr, 32'h1000);
        @(negedge clk); chk("t1_src_hold", 32'(src_valid), 32'd1);
        @(posedge clk); #1 src_ready = 1'b1;
        wait_drain("t1_drain");

        // fill channel 1 behind a stalled channel 0 job; fifth push bounces
        auto_done = 1'b0;
        @(posedge clk); #1;
        push_job(0, 0, 1'b0, 32'h4000, 32'h5000, 2, 1'b1, 1'b1);
        wait_start("t2_start");
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            push_job(1, 1, 1'b1, 32'h6000 + 32'(i * 16), 32'h7000 + 32'(i * 16), 1, 1'b1, 1'b1);
        job_chan = 1'b0; #1;
        chk("t2_ready_ch0", 32'(job_ready), 32'd1);
        push_job(1, 1, 1'b1, 32'h6fff, 32'h7fff, 1, 1'b0, 1'b1);
        auto_done = 1'b1;
        kick(2);
        wait_drain("t2_drain");

        // round robin: blocker on ch1 then 0,1,0,1 queued -> served in that order
        auto_done = 1'b0;
        @(posedge clk); #1;
        push_job(1, 0, 1'b0, 32'h8000, 32'h9000, 1, 1'b1, 1'b1);
        wait_start("t3_start");
        @(posedge clk); #1;
        push_job(0, 0, 1'b0, 32'h3000, 32'hA000, 1, 1'b1, 1'b1);
        push_job(1, 1, 1'b1, 32'h3100, 32'hA100, 2, 1'b1, 1'b1);
        push_job(0, 1, 1'b0, 32'h3200, 32'hA200, 1, 1'b1, 1'b1);
        push_job(1, 0, 1'b1, 32'h3300, 32'hA300, 2, 1'b1, 1'b1);
        auto_done = 1'b1;
        kick(1);
        wait_drain("t3_drain");

        // zero-block job on core 1: event two cycles after push, no requests
        @(posedge clk); #1;
        push_job(1, 1, 1'b0, 32'hB000, 32'hC000, 0, 1'b1, 1'b1);
        @(negedge clk); chk("t4_evt_t1", {30'd0, evt}, 32'd0);
        @(negedge clk); chk("t4_evt_t2", {30'd0, evt}, 32'd2);
        chk("t4_no_req", {29'd0, src_valid, snk_valid, eng_start}, 32'd0);
        wait_drain("t4_drain");

        // clear while running with two jobs queued
        auto_done = 1'b0;
        @(posedge clk); #1;
        push_job(0, 0, 1'b1, 32'hD000, 32'hE000, 4, 1'b1, 1'b1);
        wait_start("t5_start");
        @(posedge clk); #1;
        push_job(0, 1, 1'b0, 32'hD100, 32'hE100, 1, 1'b1, 1'b0);
        push_job(1, 1, 1'b0, 32'hD200, 32'hE200, 1, 1'b1, 1'b0);
`ifndef AES_CTRL_WATCHDOG_EN
        repeat (30) @(posedge clk);
`endif
        @(negedge clk);
        chk("t5_busy_run", 32'(busy), 32'd1);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_mode_chan", {30'd0, eng_mode, cur_chan}, 32'd2);
        @(posedge clk); #1 clear = 1'b1;
        sb.delete();
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk); chk("t5_idle", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (evt != 2'b00 || src_valid || busy) seen++;
        end
        chk("t5_quiet", 32'(seen), 32'd0);

`ifdef AES_CTRL_WATCHDOG_EN
        @(posedge clk); #1;
        push_job(0, 1, 1'b0, 32'hF000, 32'hF100, 2, 1'b1, 1'b1);
        wait_start("wd_start");
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk); chk("wd_evt_early", {30'd0, evt, err}, 32'd0);
        @(negedge clk); chk("wd_evt", {29'd0, evt, err}, 32'd5);
        @(negedge clk); chk("wd_err_sticky", {30'd0, err, busy}, 32'd2);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk); chk("wd_err_clr", 32'(err), 32'd0);
`endif

        // reset mid-job: abandoned, outputs forced low at once, no event
        @(posedge clk); #1;
        push_job(1, 1, 1'b1, 32'h1234, 32'h5678, 2, 1'b1, 1'b1);
        wait_start("t6_start");
        @(posedge clk); #1 rst = 1'b1;
        sb.delete();
        #1;
        chk("t6_rst_outs", {26'd0, busy, src_valid, eng_start, err, evt}, 32'd0);
        chk("t6_rst_chan_mode", {30'd0, cur_chan, eng_mode}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
